// File: rtl/mmio_cmd_decoder.sv
// mmio_cmd_decoder
// Peripheral endpoint of the processor's 32-bit mmio_out port.
//
// Each new command word (bit 31 toggled against the previous word) is
// decoded into a shadow copy of the game state. A COMMIT arms a transfer
// of the shadow set into the active registers. The transfer happens at the
// next clock edge that sees vblank high, so the renderer only ever sees a
// complete frame's worth of state.
//
// Optional feature macro: MMIO_DEC_ERRCNT_EN
//   defined   -> err_count counts rejected commands, saturating at 255
//   undefined -> err_count is tied to zero and no counter is built
//
// mmio_out and vblank are assumed to be already registered in this clock
// domain; there is no synchronizer here.
module mmio_cmd_decoder #(
    parameter int Y_W         = 9,
    parameter int X_W         = 10,
    parameter int NUM_PIPES   = 2,
    parameter int BIRD_Y_INIT = 240
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [31:0]               mmio_out,
    input  logic                      vblank,
    output logic [Y_W-1:0]            bird_y,
    output logic [NUM_PIPES*X_W-1:0]  pipe_x,
    output logic [NUM_PIPES*Y_W-1:0]  pipe_gap_y,
    output logic [15:0]               score,
    output logic                      commit_pending,
    output logic                      frame_ack,
    output logic [7:0]                err_count
);

    // Opcode encoding of word bits [30:28]
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_BIRD_Y = 3'd1;
    localparam logic [2:0] OP_PIPE   = 3'd2;
    localparam logic [2:0] OP_SCORE  = 3'd3;
    localparam logic [2:0] OP_COMMIT = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;

    // Reset values shared by the shadow and active register sets
    localparam logic [Y_W-1:0]           BIRD_RST  = Y_W'(BIRD_Y_INIT);
    localparam logic [NUM_PIPES*X_W-1:0] PIPE_X_RST = {(NUM_PIPES*X_W){1'b1}};
    localparam logic [NUM_PIPES*Y_W-1:0] GAP_RST    = {(NUM_PIPES*Y_W){1'b0}};
    localparam logic [15:0]              SCORE_RST  = 16'd0;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // Registered state
    state_e                     state_q,          state_d;
    logic                       prev_tog_q,       prev_tog_d;
    logic                       commit_pending_q, commit_pending_d;
    logic                       frame_ack_q,      frame_ack_d;

    logic [Y_W-1:0]             sh_bird_y_q,      sh_bird_y_d;
    logic [NUM_PIPES*X_W-1:0]   sh_pipe_x_q,      sh_pipe_x_d;
    logic [NUM_PIPES*Y_W-1:0]   sh_gap_y_q,       sh_gap_y_d;
    logic [15:0]                sh_score_q,       sh_score_d;

    logic [Y_W-1:0]             act_bird_y_q,     act_bird_y_d;
    logic [NUM_PIPES*X_W-1:0]   act_pipe_x_q,     act_pipe_x_d;
    logic [NUM_PIPES*Y_W-1:0]   act_gap_y_q,      act_gap_y_d;
    logic [15:0]                act_score_q,      act_score_d;

    // Decoded view of the incoming word
    logic                       cmd_s;
    logic [2:0]                 opcode_s;
    logic [27:0]                payload_s;
    logic [3:0]                 pipe_idx_s;
    logic [X_W-1:0]             pipe_xv_s;
    logic [Y_W-1:0]             pipe_gv_s;
    logic                       pipe_hit_s;
    logic                       copy_s;

    // Split the incoming word into fields and detect a new command
    always_comb begin
        cmd_s      = (mmio_out[31] != prev_tog_q);
        opcode_s   = mmio_out[30:28];
        payload_s  = mmio_out[27:0];
        pipe_idx_s = payload_s[27:24];
        pipe_xv_s  = payload_s[12 +: X_W];
        pipe_gv_s  = payload_s[0 +: Y_W];
        pipe_hit_s = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (pipe_idx_s == 4'(i)) begin
                pipe_hit_s = 1'b1;
            end else begin
                pipe_hit_s = pipe_hit_s;
            end
        end
        copy_s = (state_q == ST_PENDING) && vblank;
    end

    // Next-state logic: frame copy, shadow writes and commit FSM
    always_comb begin
        state_d          = state_q;
        prev_tog_d       = mmio_out[31];
        frame_ack_d      = 1'b0;
        sh_bird_y_d      = sh_bird_y_q;
        sh_pipe_x_d      = sh_pipe_x_q;
        sh_gap_y_d       = sh_gap_y_q;
        sh_score_d       = sh_score_q;
        act_bird_y_d     = act_bird_y_q;
        act_pipe_x_d     = act_pipe_x_q;
        act_gap_y_d      = act_gap_y_q;
        act_score_d      = act_score_q;

        // The copy reads the pre-edge shadow, so a shadow write landing on
        // the same edge is held back for the following commit.
        if (copy_s) begin
            act_bird_y_d = sh_bird_y_q;
            act_pipe_x_d = sh_pipe_x_q;
            act_gap_y_d  = sh_gap_y_q;
            act_score_d  = sh_score_q;
            frame_ack_d  = 1'b1;
            state_d      = ST_IDLE;
        end else begin
            state_d      = state_q;
        end

        if (cmd_s) begin
            case (opcode_s)
                OP_NOP: begin
                    sh_bird_y_d = sh_bird_y_q;
                end
                OP_BIRD_Y: begin
                    sh_bird_y_d = payload_s[0 +: Y_W];
                end
                OP_PIPE: begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if (pipe_idx_s == 4'(i)) begin
                            sh_pipe_x_d[i*X_W +: X_W] = pipe_xv_s;
                            sh_gap_y_d[i*Y_W +: Y_W]  = pipe_gv_s;
                        end else begin
                            sh_pipe_x_d[i*X_W +: X_W] = sh_pipe_x_q[i*X_W +: X_W];
                        end
                    end
                end
                OP_SCORE: begin
                    sh_score_d = payload_s[15:0];
                end
                OP_COMMIT: begin
                    // A COMMIT already waiting for vblank absorbs this one
                    if (state_q == ST_IDLE) begin
                        state_d = ST_PENDING;
                    end else begin
                        state_d = state_d;
                    end
                end
                OP_CLEAR: begin
                    sh_bird_y_d = BIRD_RST;
                    sh_pipe_x_d = PIPE_X_RST;
                    sh_gap_y_d  = GAP_RST;
                    sh_score_d  = SCORE_RST;
                end
                default: begin
                    sh_bird_y_d = sh_bird_y_q;
                end
            endcase
        end else begin
            sh_bird_y_d = sh_bird_y_q;
        end

        commit_pending_d = (state_d == ST_PENDING);
    end

    // State, shadow and active registers with synchronous reset
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            prev_tog_q       <= 1'b0;
            commit_pending_q <= 1'b0;
            frame_ack_q      <= 1'b0;
            sh_bird_y_q      <= BIRD_RST;
            sh_pipe_x_q      <= PIPE_X_RST;
            sh_gap_y_q       <= GAP_RST;
            sh_score_q       <= SCORE_RST;
            act_bird_y_q     <= BIRD_RST;
            act_pipe_x_q     <= PIPE_X_RST;
            act_gap_y_q      <= GAP_RST;
            act_score_q      <= SCORE_RST;
        end else begin
            state_q          <= state_d;
            prev_tog_q       <= prev_tog_d;
            commit_pending_q <= commit_pending_d;
            frame_ack_q      <= frame_ack_d;
            sh_bird_y_q      <= sh_bird_y_d;
            sh_pipe_x_q      <= sh_pipe_x_d;
            sh_gap_y_q       <= sh_gap_y_d;
            sh_score_q       <= sh_score_d;
            act_bird_y_q     <= act_bird_y_d;
            act_pipe_x_q     <= act_pipe_x_d;
            act_gap_y_q      <= act_gap_y_d;
            act_score_q      <= act_score_d;
        end
    end

`ifdef MMIO_DEC_ERRCNT_EN
    logic       reject_s;
    logic [7:0] err_count_q, err_count_d;

    // Rejected commands: illegal opcodes and PIPE writes to a missing slot
    always_comb begin
        if (cmd_s) begin
            case (opcode_s)
                OP_PIPE: reject_s = !pipe_hit_s;
                3'd6:    reject_s = 1'b1;
                3'd7:    reject_s = 1'b1;
                default: reject_s = 1'b0;
            endcase
        end else begin
            reject_s = 1'b0;
        end
        if (reject_s && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Saturating reject counter
    always_ff @(posedge clock) begin
        if (rst) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

    assign bird_y         = act_bird_y_q;
    assign pipe_x         = act_pipe_x_q;
    assign pipe_gap_y     = act_gap_y_q;
    assign score          = act_score_q;
    assign commit_pending = commit_pending_q;
    assign frame_ack      = frame_ack_q;

endmodule
